// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM state encodings and
// default vector table placement.
package interrupt_controller_pkg;

    typedef enum logic [1:0] {
        IC_IDLE    = 2'd0,
        IC_REQ     = 2'd1,
        IC_SERVICE = 2'd2
    } ic_state_e;

    localparam logic [7:0] IC_VEC_BASE_DEF   = 8'hF0;
    localparam int         IC_VEC_STRIDE_DEF = 4;

endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// Fixed-priority encoder: bit 0 has the highest priority; reports whether any
// request is set and the index of the lowest set bit.
module interrupt_controller_priority_encoder #(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output logic [2:0]   idx_o
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = 3'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = 3'(i);
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: latches rising edges as pending, arbitrates the unmasked
// lines and runs a request/ack/service/return handshake with the control unit.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int               NIRQ       = 4,
    parameter int               VEC_W      = 8,
    parameter logic [VEC_W-1:0] VEC_BASE   = VEC_W'(IC_VEC_BASE_DEF),
    parameter int               VEC_STRIDE = IC_VEC_STRIDE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NIRQ-1:0]  irq_in,
    input  logic             mask_wr,
    input  logic [NIRQ-1:0]  mask_data,
    input  logic             gie_set,
    input  logic             gie_clr,
    input  logic             int_ack,
    input  logic             reti,
    output logic             int_req,
    output logic [VEC_W-1:0] vector,
    output logic [2:0]       int_id,
    output logic             in_service,
    output logic [NIRQ-1:0]  pending
);

    ic_state_e        state_q, state_d;
    logic [NIRQ-1:0]  pending_q, pending_d;
    logic [NIRQ-1:0]  mask_q, mask_d;
    logic [NIRQ-1:0]  irq_prev_q;
    logic             gie_q, gie_d;
    logic             int_req_q, int_req_d;
    logic [VEC_W-1:0] vector_q, vector_d;
    logic [2:0]       int_id_q, int_id_d;
    logic             in_service_q, in_service_d;

    logic             win_valid_s;
    logic [2:0]       win_idx_s;
    logic [NIRQ-1:0]  edges_s;
    logic [VEC_W-1:0] vec_calc_s;
    logic             ack_s;
    logic             ret_s;

    interrupt_controller_priority_encoder #(.N(NIRQ)) u_prio (
        .req_i   (pending_q & mask_q),
        .valid_o (win_valid_s),
        .idx_o   (win_idx_s)
    );

    assign edges_s    = irq_in & ~irq_prev_q;
    assign vec_calc_s = VEC_BASE + VEC_W'(VEC_STRIDE * int'(win_idx_s));
    assign ack_s      = (state_q == IC_REQ) && int_ack;
    assign ret_s      = (state_q == IC_SERVICE) && reti;

    // Next-state logic for the FSM and all architectural registers.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        mask_d       = mask_wr ? mask_data : mask_q;
        gie_d        = gie_q;
        int_req_d    = int_req_q;
        vector_d     = vector_q;
        int_id_d     = int_id_q;
        in_service_d = in_service_q;

        case (state_q)
            IC_IDLE: begin
                if (gie_q && win_valid_s) begin
                    state_d   = IC_REQ;
                    int_req_d = 1'b1;
                    int_id_d  = win_idx_s;
                    vector_d  = vec_calc_s;
                end else begin
                    state_d = IC_IDLE;
                end
            end
            IC_REQ: begin
                if (int_ack) begin
                    state_d      = IC_SERVICE;
                    int_req_d    = 1'b0;
                    in_service_d = 1'b1;
                    for (int i = 0; i < NIRQ; i++) begin
                        if (int_id_q == 3'(i)) begin
                            pending_d[i] = 1'b0;
                        end else begin
                            pending_d[i] = pending_d[i];
                        end
                    end
                end else begin
                    state_d = IC_REQ;
                end
            end
            IC_SERVICE: begin
                if (reti) begin
                    state_d      = IC_IDLE;
                    in_service_d = 1'b0;
                end else begin
                    state_d = IC_SERVICE;
                end
            end
            default: begin
                state_d      = IC_IDLE;
                int_req_d    = 1'b0;
                in_service_d = 1'b0;
            end
        endcase

        // A fresh edge on the acknowledged line re-arms it.
        pending_d = pending_d | edges_s;

        // Later assignments win: ack and gie_clr override any set.
        if (ret_s || gie_set) begin
            gie_d = 1'b1;
        end else begin
            gie_d = gie_d;
        end
        if (ack_s || gie_clr) begin
            gie_d = 1'b0;
        end else begin
            gie_d = gie_d;
        end
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IC_IDLE;
            pending_q    <= '0;
            mask_q       <= '0;
            irq_prev_q   <= '0;
            gie_q        <= 1'b0;
            int_req_q    <= 1'b0;
            vector_q     <= '0;
            int_id_q     <= 3'd0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            irq_prev_q   <= irq_in;
            gie_q        <= gie_d;
            int_req_q    <= int_req_d;
            vector_q     <= vector_d;
            int_id_q     <= int_id_d;
            in_service_q <= in_service_d;
        end
    end

    assign int_req    = int_req_q;
    assign vector     = vector_q;
    assign int_id     = int_id_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller (NIRQ=4, VEC_W=8).
module tb_interrupt_controller;

    logic       clk;
    logic       rst;
    logic [3:0] irq_in;
    logic       mask_wr;
    logic [3:0] mask_data;
    logic       gie_set;
    logic       gie_clr;
    logic       int_ack;
    logic       reti;
    logic       int_req;
    logic [7:0] vector;
    logic [2:0] int_id;
    logic       in_service;
    logic [3:0] pending;

    int n_cmp;
    int n_bad;

    interrupt_controller dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_wr    (mask_wr),
        .mask_data  (mask_data),
        .gie_set    (gie_set),
        .gie_clr    (gie_clr),
        .int_ack    (int_ack),
        .reti       (reti),
        .int_req    (int_req),
        .vector     (vector),
        .int_id     (int_id),
        .in_service (in_service),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drop all single-cycle strobes.
    task automatic idle_inputs();
        mask_wr = 1'b0;
        gie_set = 1'b0;
        gie_clr = 1'b0;
        int_ack = 1'b0;
        reti    = 1'b0;
    endtask

    task automatic pulse_irq(input logic [3:0] lines);
        irq_in = lines;
        tick();
        irq_in = 4'b0000;
    endtask

    task automatic do_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic do_reti();
        reti = 1'b1;
        tick();
        reti = 1'b0;
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_wr   = 1'b1;
        mask_data = m;
        tick();
        mask_wr   = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        irq_in    = 4'b0000;
        mask_data = 4'b0000;
        idle_inputs();

        // 1: reset
        tick();
        rst = 1'b0;
        check_val("rst_int_req", 32'(int_req), 32'd0);
        check_val("rst_vector", 32'(vector), 32'd0);
        check_val("rst_int_id", 32'(int_id), 32'd0);
        check_val("rst_in_service", 32'(in_service), 32'd0);
        check_val("rst_pending", 32'(pending), 32'd0);
        check_val("rst_state", 32'(dut.state_q), 32'd0);
        check_val("rst_mask", 32'(dut.mask_q), 32'd0);

        // 2: single irq on line 2
        mask_wr   = 1'b1;
        mask_data = 4'b1111;
        gie_set   = 1'b1;
        tick();
        idle_inputs();
        pulse_irq(4'b0100);
        check_val("s2_pending", 32'(pending), 32'h4);
        check_val("s2_no_req_yet", 32'(int_req), 32'd0);
        tick();
        check_val("s2_int_req", 32'(int_req), 32'd1);
        check_val("s2_int_id", 32'(int_id), 32'd2);
        check_val("s2_vector", 32'(vector), 32'hF8);
        do_ack();
        check_val("s2_ack_pending", 32'(pending), 32'd0);
        check_val("s2_ack_in_service", 32'(in_service), 32'd1);
        check_val("s2_ack_int_req", 32'(int_req), 32'd0);
        check_val("s2_ack_gie", 32'(dut.gie_q), 32'd0);
        do_reti();
        check_val("s2_reti_in_service", 32'(in_service), 32'd0);
        check_val("s2_reti_gie", 32'(dut.gie_q), 32'd1);

        // 3: priority between lines 1 and 3
        pulse_irq(4'b1010);
        check_val("s3_pending", 32'(pending), 32'hA);
        tick();
        check_val("s3_req1", 32'(int_req), 32'd1);
        check_val("s3_id1", 32'(int_id), 32'd1);
        check_val("s3_vec1", 32'(vector), 32'hF4);
        do_ack();
        check_val("s3_pending_after_ack", 32'(pending), 32'h8);
        tick();
        check_val("s3_no_nesting", 32'(int_req), 32'd0);
        do_reti();
        check_val("s3_reti_no_req", 32'(int_req), 32'd0);
        tick();
        check_val("s3_req3", 32'(int_req), 32'd1);
        check_val("s3_id3", 32'(int_id), 32'd3);
        check_val("s3_vec3", 32'(vector), 32'hFC);
        do_ack();
        do_reti();

        // 4: masking and no retraction
        write_mask(4'b1110);
        pulse_irq(4'b0001);
        tick();
        check_val("s4_masked_no_req", 32'(int_req), 32'd0);
        check_val("s4_masked_pending", 32'(pending), 32'h1);
        write_mask(4'b1111);
        check_val("s4_mask_delay", 32'(int_req), 32'd0);
        tick();
        check_val("s4_unmasked_req", 32'(int_req), 32'd1);
        check_val("s4_id0", 32'(int_id), 32'd0);
        check_val("s4_vec0", 32'(vector), 32'hF0);
        mask_wr   = 1'b1;
        mask_data = 4'b0000;
        gie_clr   = 1'b1;
        tick();
        idle_inputs();
        check_val("s4_hold_req", 32'(int_req), 32'd1);
        check_val("s4_mask_applied", 32'(dut.mask_q), 32'd0);
        tick();
        check_val("s4_hold_req2", 32'(int_req), 32'd1);
        check_val("s4_hold_vec", 32'(vector), 32'hF0);
        do_ack();
        check_val("s4_ack_req", 32'(int_req), 32'd0);
        check_val("s4_ack_service", 32'(in_service), 32'd1);
        do_reti();
        write_mask(4'b1111);

        // 5: edge cases
        reti    = 1'b1;
        int_ack = 1'b1;
        tick();
        idle_inputs();
        check_val("s5_idle_in_service", 32'(in_service), 32'd0);
        check_val("s5_idle_int_req", 32'(int_req), 32'd0);
        check_val("s5_idle_state", 32'(dut.state_q), 32'd0);
        check_val("s5_idle_gie", 32'(dut.gie_q), 32'd1);
        pulse_irq(4'b0010);
        tick();
        check_val("s5_req1", 32'(int_req), 32'd1);
        irq_in  = 4'b0010;
        int_ack = 1'b1;
        tick();
        idle_inputs();
        irq_in  = 4'b0000;
        check_val("s5_ack_edge_pending", 32'(pending), 32'h2);
        check_val("s5_ack_edge_service", 32'(in_service), 32'd1);
        reti    = 1'b1;
        gie_clr = 1'b1;
        tick();
        idle_inputs();
        check_val("s5_reti_clr_gie", 32'(dut.gie_q), 32'd0);
        tick();
        check_val("s5_reti_clr_no_req", 32'(int_req), 32'd0);
        gie_set = 1'b1;
        tick();
        idle_inputs();
        tick();
        check_val("s5_rearm_req", 32'(int_req), 32'd1);
        check_val("s5_rearm_id", 32'(int_id), 32'd1);
        do_ack();
        do_reti();
        gie_set = 1'b1;
        gie_clr = 1'b1;
        tick();
        idle_inputs();
        check_val("s5_set_clr_gie", 32'(dut.gie_q), 32'd0);
        pulse_irq(4'b0100);
        tick();
        check_val("s5_gie0_no_req", 32'(int_req), 32'd0);
        check_val("s5_gie0_pending", 32'(pending), 32'h4);

        // 6: reset during service
        gie_set = 1'b1;
        tick();
        idle_inputs();
        check_val("s6_pre_req_low", 32'(int_req), 32'd0);
        tick();
        check_val("s6_req2", 32'(int_req), 32'd1);
        check_val("s6_vec2", 32'(vector), 32'hF8);
        do_ack();
        check_val("s6_in_service", 32'(in_service), 32'd1);
        irq_in = 4'b1000;
        rst    = 1'b1;
        tick();
        rst    = 1'b0;
        check_val("s6_rst_in_service", 32'(in_service), 32'd0);
        check_val("s6_rst_int_req", 32'(int_req), 32'd0);
        check_val("s6_rst_state", 32'(dut.state_q), 32'd0);
        check_val("s6_rst_pending", 32'(pending), 32'd0);
        tick();
        check_val("s6_held_irq_pending", 32'(pending), 32'h8);
        check_val("s6_mask_cleared", 32'(dut.mask_q), 32'd0);
        irq_in = 4'b0000;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
